// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared constants and helpers for the memory-port arbiter.
//               Holds the state encodings, length codes, the IO region tag,
//               the default channel roles and a few small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;

    // Transfer length codes (byte count minus one)
    localparam logic [1:0] c_LEN_B = 2'd0;
    localparam logic [1:0] c_LEN_H = 2'd1;
    localparam logic [1:0] c_LEN_W = 2'd3;

    // addr[17:16] value that selects the memory-mapped IO region
    localparam logic [1:0] c_IO_REGION = 2'b11;

    // Default channel roles
    localparam int c_CH_IF  = 0;
    localparam int c_CH_SLB = 1;

    // Width of a channel index; a single channel still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Code 2 has no meaning as a length, so it is widened to a full word
    function automatic logic [1:0] norm_len(input logic [1:0] len);
        return (len == 2'd2) ? c_LEN_W : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_select
// Description : Combinational grant picker. Fixed mode grants the highest
//               requesting index; round-robin mode grants the first
//               requester found walking upward from i_ptr (with wrap).
// Ports       : i_req   - per-channel request vector
//               i_ptr   - round-robin search start (ignored in fixed mode)
//               o_valid - at least one request present
//               o_grant - index of the granted channel
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int RR_MODE = 0,
    parameter int IDX_W   = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_grant
);

    assign o_valid = |i_req;

    if (RR_MODE == 0) begin : g_fixed
        logic w_unused_ptr;
        assign w_unused_ptr = ^i_ptr;

        // Ascending scan: the last (highest) requester seen wins
        always_comb begin
            o_grant = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_req[i]) o_grant = IDX_W'(i);
            end
        end
    end else begin : g_rr
        int w_j;

        // Scan offsets from farthest to nearest so the requester closest
        // to the pointer overwrites everything further away
        always_comb begin
            o_grant = '0;
            w_j     = 0;
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                w_j = int'(i_ptr) + k;
                if (w_j >= NUM_CH) w_j = w_j - NUM_CH;
                if (i_req[w_j]) o_grant = IDX_W'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates NUM_CH requesters onto one byte-wide memory port
//               and serialises 1/2/4-byte little-endian transfers. One done
//               pulse per transfer carries the assembled read word.
// Ports       : clk_in/rst_in  - clock, synchronous active-high reset
//               rdy_in         - global pause (freezes all state)
//               flush          - aborts reads on FLUSH_MASK channels
//               ch_req/ch_wr/ch_len/ch_addr/ch_wdata - per-channel request
//               ch_done/ch_rdata - completion pulse and read result
//               busy           - transfer in progress
//               mem_din/mem_dout/mem_a/mem_wr - byte memory port
//               io_buffer_full - IO write back-pressure
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                NUM_CH     = 2,
    parameter int                RR_MODE    = 0,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = NUM_CH'(1),
    parameter int                ADDR_W     = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_wr,
    input  logic [2*NUM_CH-1:0]      ch_len,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [32*NUM_CH-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [31:0]              ch_rdata,
    output logic                     busy,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    localparam int c_IDX_W = idx_width(NUM_CH);

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_ch;
    logic [ADDR_W-1:0]  r_addr;
    logic [1:0]         r_len;
    logic [31:0]        r_wdata;
    logic [1:0]         r_cnt;       // index of the byte currently on the port
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [NUM_CH-1:0]  r_done;
    logic [31:0]        r_rdata;
    logic [ADDR_W-1:0]  r_mem_a;
    logic               r_mem_wr;
    logic [7:0]         r_mem_dout;
    logic               r_rd_iss;    // a read byte address is on the port
    logic               r_cap;       // mem_din holds a byte to capture
    logic [1:0]         r_cap_idx;   // lane for the byte being captured

    logic [ADDR_W-1:0]  w_addr_arr  [NUM_CH];
    logic [31:0]        w_wdata_arr [NUM_CH];
    logic [1:0]         w_len_arr   [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_addr_arr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = ch_wdata[g*32 +: 32];
        assign w_len_arr[g]   = ch_len[g*2 +: 2];
    end

    // Flushed channels are hidden from arbitration for that cycle
    logic [NUM_CH-1:0]  w_req_eff;
    logic               w_gnt_valid;
    logic [c_IDX_W-1:0] w_gnt;

    assign w_req_eff = ch_req & ~(flush ? FLUSH_MASK : '0);

    mem_arb_select #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE),
        .IDX_W   (c_IDX_W)
    ) u_select (
        .i_req   (w_req_eff),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_gnt_valid),
        .o_grant (w_gnt)
    );

    logic              w_io_addr;
    logic              w_io_stall;
    logic [1:0]        w_cnt_inc;
    logic [ADDR_W-1:0] w_addr_nxt;

    if (ADDR_W >= 18) begin : g_io
        assign w_io_addr = (r_mem_a[17:16] == c_IO_REGION);
    end else begin : g_no_io
        assign w_io_addr = 1'b0;
    end

    // A pending IO write byte is held off while the UART buffer is full
    assign w_io_stall = r_mem_wr & io_buffer_full & w_io_addr;
    assign w_cnt_inc  = r_cnt + 2'd1;
    assign w_addr_nxt = r_addr + ADDR_W'(w_cnt_inc);

    // The arbitration cycle always separates the last read byte issue from
    // the first write byte issue, so read->write turnaround needs no extra
    // bubble state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= c_IDLE;
            r_ch       <= '0;
            r_addr     <= '0;
            r_len      <= c_LEN_B;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_mem_a    <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_dout <= '0;
            r_rd_iss   <= 1'b0;
            r_cap      <= 1'b0;
            r_cap_idx  <= '0;
        end else if (rdy_in) begin
            r_done <= '0;
            case (r_state)
                c_IDLE: begin
                    // No grant in a done cycle: the finished requester is
                    // still holding its request level
                    if (r_done == '0 && w_gnt_valid) begin
                        r_ch     <= w_gnt;
                        r_addr   <= w_addr_arr[w_gnt];
                        r_len    <= norm_len(w_len_arr[w_gnt]);
                        r_wdata  <= w_wdata_arr[w_gnt];
                        r_cnt    <= '0;
                        r_mem_a  <= w_addr_arr[w_gnt];
                        r_rr_ptr <= (w_gnt == c_IDX_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
                        if (ch_wr[w_gnt]) begin
                            r_state    <= c_WR;
                            r_mem_wr   <= 1'b1;
                            r_mem_dout <= w_wdata_arr[w_gnt][7:0];
                        end else begin
                            r_state  <= c_RD;
                            r_rd_iss <= 1'b1;
                            r_cap    <= 1'b0;
                            r_rdata  <= '0;
                        end
                    end
                end

                c_RD: begin
                    if (flush && FLUSH_MASK[r_ch]) begin
                        // Abandon: bytes still in flight are never captured
                        r_state  <= c_IDLE;
                        r_mem_a  <= '0;
                        r_rd_iss <= 1'b0;
                        r_cap    <= 1'b0;
                    end else begin
                        if (r_cap) begin
                            r_rdata[8*r_cap_idx +: 8] <= mem_din;
                            if (r_cap_idx == r_len) begin
                                r_done[r_ch] <= 1'b1;
                                r_state      <= c_IDLE;
                            end
                        end
                        // Capture trails issue by one cycle
                        r_cap     <= r_rd_iss;
                        r_cap_idx <= r_cnt;
                        if (r_rd_iss) begin
                            if (r_cnt == r_len) begin
                                r_rd_iss <= 1'b0;
                                r_mem_a  <= '0;
                            end else begin
                                r_cnt   <= w_cnt_inc;
                                r_mem_a <= w_addr_nxt;
                            end
                        end
                    end
                end

                c_WR: begin
                    if (!w_io_stall) begin
                        if (r_cnt == r_len) begin
                            r_done[r_ch] <= 1'b1;
                            r_state      <= c_IDLE;
                            r_mem_wr     <= 1'b0;
                            r_mem_a      <= '0;
                            r_mem_dout   <= '0;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_mem_a    <= w_addr_nxt;
                            r_mem_dout <= r_wdata[8*w_cnt_inc +: 8];
                        end
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign ch_done  = r_done;
    assign ch_rdata = r_rdata;
    assign busy     = (r_state != c_IDLE);
    assign mem_dout = r_mem_dout;
    assign mem_a    = w_io_stall ? '0 : r_mem_a;
    assign mem_wr   = r_mem_wr & rdy_in & ~w_io_stall;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. One instance
//               uses the default two-channel fixed-priority configuration
//               with a byte RAM model; a second three-channel round-robin
//               instance checks grant rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default-configuration DUT ----------------
    logic        rst, rdy, flush, io_full;
    logic [1:0]  req, wr, done;
    logic [3:0]  len;
    logic [63:0] addr, wdata;
    logic [31:0] rdata, mem_a;
    logic        busy, mem_wr;
    logic [7:0]  mem_din, mem_dout;

    mem_arbiter dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        .flush          (flush),
        .ch_req         (req),
        .ch_wr          (wr),
        .ch_len         (len),
        .ch_addr        (addr),
        .ch_wdata       (wdata),
        .ch_done        (done),
        .ch_rdata       (rdata),
        .busy           (busy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_full)
    );

    // ---------------- round-robin DUT ----------------
    logic [2:0]  rr_req, rr_done;
    logic [31:0] rr_rdata, rr_a;
    logic        rr_busy, rr_wr;
    logic [7:0]  rr_dout;

    mem_arbiter #(
        .NUM_CH     (3),
        .RR_MODE    (1),
        .FLUSH_MASK (3'b001),
        .ADDR_W     (32)
    ) dut_rr (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (1'b1),
        .flush          (1'b0),
        .ch_req         (rr_req),
        .ch_wr          (3'b000),
        .ch_len         (6'b000000),
        .ch_addr        (96'h0),
        .ch_wdata       (96'h0),
        .ch_done        (rr_done),
        .ch_rdata       (rr_rdata),
        .busy           (rr_busy),
        .mem_din        (8'h5A),
        .mem_dout       (rr_dout),
        .mem_a          (rr_a),
        .mem_wr         (rr_wr),
        .io_buffer_full (1'b0)
    );

    // ---------------- memory model ----------------
    // Read data appears the cycle after the address; paused with rdy low.
    logic [7:0]  ram    [0:4095];
    logic [31:0] wlog_a [0:15];
    logic [7:0]  wlog_d [0:15];
    int          n_wr;

    always @(posedge clk) begin
        if (rst) begin
            n_wr <= 0;
        end else if (rdy) begin
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) begin
                wlog_a[n_wr[3:0]] <= mem_a;
                wlog_d[n_wr[3:0]] <= mem_dout;
                n_wr              <= n_wr + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the
    // falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    logic [2:0] rr_exp [4];
    int         n0;
    int         got;
    int         gap;

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
        req = '0; wr = '0; len = '0; addr = '0; wdata = '0; rr_req = '0;

        // ---- reset state ----
        step(); step(); step();
        mid();
        check_val("rst_busy",   busy,     0);
        check_val("rst_done",   done,     0);
        check_val("rst_rdata",  rdata,    0);
        check_val("rst_mem_a",  mem_a,    0);
        check_val("rst_mem_wr", mem_wr,   0);
        check_val("rst_dout",   mem_dout, 0);
        check_val("rst_rrbusy", rr_busy,  0);
        step(); rst = 1'b0;
        mid();

        // ---- 4-byte read on ch0 at 0x1000 ----
        step(); req = 2'b01; wr = 2'b00; len = 4'b0011; addr = {32'h0, 32'h1000};
        mid();  check_val("rd4_T_busy", busy, 0);
        for (int k = 0; k < 4; k++) begin
            step(); mid();
            check_val("rd4_addr", mem_a, 32'h1000 + k);
            check_val("rd4_wr",   mem_wr, 0);
        end
        step(); mid(); check_val("rd4_T5_done", done, 2'b00);
        step(); mid();
        check_val("rd4_T6_done", done,  2'b01);
        check_val("rd4_rdata",   rdata, 32'h44332211);
        req = 2'b00;

        // ---- ch0 1-byte read vs ch1 2-byte write, fixed priority ----
        step(); req = 2'b11; wr = 2'b10; len = 4'b0100;
        addr = {32'h200, 32'h1002}; wdata = {32'h0000BEEF, 32'h0};
        mid();
        step(); mid();
        check_val("pri_b0_wr", mem_wr, 1);
        check_val("pri_b0_a",  mem_a, 32'h200);
        check_val("pri_b0_d",  mem_dout, 8'hEF);
        step(); mid();
        check_val("pri_b1_wr", mem_wr, 1);
        check_val("pri_b1_a",  mem_a, 32'h201);
        check_val("pri_b1_d",  mem_dout, 8'hBE);
        step(); mid();
        check_val("pri_wdone", done, 2'b10);
        check_val("pri_wr_off", mem_wr, 0);
        req = 2'b01;
        step(); mid();
        check_val("pri_T4_busy", busy, 0);
        check_val("pri_T4_done", done, 2'b00);
        step(); mid();
        check_val("pri_T5_busy", busy, 1);
        check_val("pri_T5_a",    mem_a, 32'h1002);
        step(); mid();
        step(); mid();
        check_val("pri_rdone", done,  2'b01);
        check_val("pri_rdata", rdata, 32'h33);
        check_val("pri_nwr",   n_wr,  2);
        check_val("pri_log_a", wlog_a[1], 32'h201);
        check_val("pri_log_d", wlog_d[0], 8'hEF);
        req = 2'b00;

        // ---- IO write stalled by a full UART buffer ----
        step(); n0 = n_wr;
        req = 2'b10; wr = 2'b10; len = 4'b0000;
        addr = {32'h30000, 32'h0}; wdata = {32'h41, 32'h0}; io_full = 1'b1;
        mid();
        for (int k = 1; k <= 5; k++) begin
            step(); mid();
            check_val("io_stall_wr", mem_wr, 0);
            check_val("io_stall_a",  mem_a, 0);
        end
        step(); io_full = 1'b0;
        mid();
        check_val("io_wr",   mem_wr, 1);
        check_val("io_a",    mem_a, 32'h30000);
        check_val("io_d",    mem_dout, 8'h41);
        step(); mid();
        check_val("io_done", done, 2'b10);
        check_val("io_nwr",  n_wr - n0, 1);
        req = 2'b00;

        // ---- flush during a 4-byte ch0 read, ch1 waiting ----
        step(); req = 2'b01; wr = 2'b00; len = 4'b0011; addr = {32'h3, 32'h1000};
        mid();
        step(); mid();
        step(); req = 2'b11;
        mid();
        step(); flush = 1'b1; req = 2'b10;
        mid(); check_val("fl_T3_done", done, 2'b00);
        step(); flush = 1'b0;
        mid();
        check_val("fl_T4_busy", busy, 0);
        check_val("fl_T4_a",    mem_a, 0);
        check_val("fl_T4_done", done, 2'b00);
        step(); mid();
        check_val("fl_T5_busy", busy, 1);
        check_val("fl_T5_a",    mem_a, 32'h3);
        step(); mid();
        check_val("fl_T6_done", done, 2'b00);
        step(); mid();
        check_val("fl_ch1_done", done,  2'b10);
        check_val("fl_ch1_data", rdata, 32'h44);
        req = 2'b00;

        // ---- rdy pause mid write; length code 2 means four bytes ----
        step(); n0 = n_wr;
        req = 2'b10; wr = 2'b10; len = 4'b1000;
        addr = {32'h100, 32'h0}; wdata = {32'hA1B2C3D4, 32'h0};
        mid();
        step(); mid();
        check_val("pz_b0_a", mem_a, 32'h100);
        check_val("pz_b0_d", mem_dout, 8'hD4);
        step(); mid();
        check_val("pz_b1_a", mem_a, 32'h101);
        check_val("pz_b1_d", mem_dout, 8'hC3);
        for (int k = 0; k < 3; k++) begin
            step(); rdy = 1'b0;
            mid(); check_val("pz_paused_wr", mem_wr, 0);
        end
        step(); rdy = 1'b1;
        mid();
        check_val("pz_b2_wr", mem_wr, 1);
        check_val("pz_b2_a",  mem_a, 32'h102);
        check_val("pz_b2_d",  mem_dout, 8'hB2);
        step(); mid();
        check_val("pz_b3_a",  mem_a, 32'h103);
        check_val("pz_b3_d",  mem_dout, 8'hA1);
        step(); mid();
        check_val("pz_done",  done, 2'b10);
        check_val("pz_nwr",   n_wr - n0, 4);
        check_val("pz_log_a", wlog_a[(n0 + 2) % 16], 32'h102);
        check_val("pz_log_d", wlog_d[(n0 + 3) % 16], 8'hA1);
        req = 2'b00;

        // ---- round-robin rotation, all channels requesting ----
        step(); rr_req = 3'b111;
        mid();
        for (int g = 0; g < 4; g++) begin
            got = 0;
            gap = 0;
            for (int c = 0; c < 12 && got == 0; c++) begin
                step(); mid();
                gap = c;
                if (rr_done != 3'b000) got = 1;
            end
            check_val("rr_seen",  got, 1);
            check_val("rr_order", rr_done, rr_exp[g]);
            check_val("rr_data",  rr_rdata, 32'h5A);
            if (g > 0) check_val("rr_gap", gap, 3);
        end
        rr_req = 3'b000;
        step(); mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
